// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: holds one load/store/halt request for LATENCY cycles.
// Optional misaligned-access rejection when MEM_ALIGN_CHECK_EN is defined.
module mem_access_ctrl #(
   parameter int unsigned LATENCY = 1,
   parameter int unsigned CNT_W   = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   input  logic        req_write,
   input  logic        req_read,
   input  logic        req_halt,
   input  logic        flush,
   input  logic [15:0] mem_rdata,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic        mem_write,
   output logic        mem_read,
   output logic        mem_halt,
   output logic        stall,
   output logic        rsp_valid,
   output logic [15:0] rsp_rdata,
   output logic        err,
   output logic        halted
);

   typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [15:0]        addr_q, addr_d;
   logic [15:0]        wdata_q, wdata_d;
   logic               rd_q, rd_d;
   logic               wr_q, wr_d;
   logic               mhalt_q, mhalt_d;
   logic               halt_pend_q, halt_pend_d;
   logic               halted_q, halted_d;
   logic [15:0]        rdata_q, rdata_d;
   logic               err_q, err_d;

   logic accept, bad_rw, misalign, single, halt_only;

   always_comb begin
      bad_rw = req_read & req_write;
`ifdef MEM_ALIGN_CHECK_EN
      misalign = (req_read ^ req_write) & req_addr[0];
`else
      misalign = 1'b0;
`endif
      single    = (req_read ^ req_write) & ~misalign;
      halt_only = req_halt & ~req_read & ~req_write;
      // Reset gates accept so stall drops the moment rst goes low.
      accept    = rst && (state_q != StAccess) && req_valid && !flush && !halted_q &&
                  (req_read || req_write || req_halt);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rd_q        <= 1'b0;
         wr_q        <= 1'b0;
         mhalt_q     <= 1'b0;
         halt_pend_q <= 1'b0;
         halted_q    <= 1'b0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rd_q        <= rd_d;
         wr_q        <= wr_d;
         mhalt_q     <= mhalt_d;
         halt_pend_q <= halt_pend_d;
         halted_q    <= halted_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle, StResp: begin
            if (accept) state_d = single ? StAccess : StResp;
            else        state_d = StIdle;
         end
         StAccess: begin
            if (cnt_q == '0) state_d = StResp;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rd_d        = rd_q;
      wr_d        = wr_q;
      halt_pend_d = halt_pend_q;
      halted_d    = halted_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      if (accept) begin
         addr_d      = req_addr;
         wdata_d     = req_wdata;
         rd_d        = single & req_read;
         wr_d        = single & req_write;
         halt_pend_d = single & req_halt;
         cnt_d       = CNT_W'(LATENCY - 1);
         if (!single) begin
            // Error and halt-only requests respond next cycle without touching memory.
            err_d    = bad_rw | misalign;
            rdata_d  = '0;
            halted_d = halt_only;
         end
      end else if (state_q == StAccess) begin
         if (cnt_q == '0) begin
            rdata_d     = rd_q ? mem_rdata : 16'h0000;
            err_d       = 1'b0;
            rd_d        = 1'b0;
            wr_d        = 1'b0;
            halted_d    = halted_q | halt_pend_q;
            halt_pend_d = 1'b0;
         end else begin
            cnt_d = cnt_q - CNT_W'(1);
         end
      end
      // Dump strobe lands on the final access cycle, or immediately for a bare HALT.
      mhalt_d = (accept && halt_only) ||
                (state_d == StAccess && cnt_d == '0 && halt_pend_d);
   end

   always_comb begin
      stall     = accept || (state_q == StAccess);
      rsp_valid = (state_q == StResp);
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      mem_read  = rd_q;
      mem_write = wr_q;
      mem_halt  = mhalt_q;
      rsp_rdata = rdata_q;
      err       = err_q;
      halted    = halted_q;
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: stimulus pushes expected responses, a monitor pops them.
module tb_mem_access_ctrl;

   localparam int LAT = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic [15:0] req_addr = '0;
   logic [15:0] req_wdata = '0;
   logic        req_write = 1'b0;
   logic        req_read = 1'b0;
   logic        req_halt = 1'b0;
   logic        flush = 1'b0;
   logic [15:0] mem_rdata;
   logic [15:0] mem_addr, mem_wdata, rsp_rdata;
   logic        mem_write, mem_read, mem_halt, stall, rsp_valid, err, halted;

   mem_access_ctrl #(.LATENCY(LAT), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_write(req_write), .req_read(req_read),
      .req_halt(req_halt), .flush(flush), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_read(mem_read),
      .mem_halt(mem_halt), .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .err(err), .halted(halted)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [15:0] mem [0:255];
   always @(negedge clk) if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;
   assign mem_rdata = mem_read ? mem[mem_addr[7:0]] : 16'h0000;

   typedef struct {
      logic [15:0] rdata;
      logic        err;
      int          cyc;
   } exp_t;
   exp_t sbq[$];

   int checks = 0;
   int errors = 0;
   int rsp_seen = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst && rsp_valid) begin
            rsp_seen++;
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rsp: got rsp_valid=1 expected none (cycle %0d)", cyc);
            end else begin
               e = sbq.pop_front();
               chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
               chk("rsp_err", 32'(err), 32'(e.err));
               chk("rsp_cycle", cyc, e.cyc);
            end
         end
      end
   end

   // lat < 0 means no response is expected from this request.
   task automatic send(input logic [15:0] a, input logic [15:0] wd, input logic r,
                       input logic w, input logic h, input logic f, input logic exp_stall,
                       input int lat, input logic [15:0] erd, input logic eerr);
      exp_t e;
      @(posedge clk); #1;
      req_addr = a; req_wdata = wd; req_read = r; req_write = w; req_halt = h;
      flush = f; req_valid = 1'b1;
      if (lat >= 0) begin
         e.rdata = erd; e.err = eerr; e.cyc = cyc + lat;
         sbq.push_back(e);
      end
      #1 chk("stall_c0", 32'(stall), 32'(exp_stall));
      @(posedge clk); #1;
      req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0; req_halt = 1'b0; flush = 1'b0;
   endtask

   // Checks c1..cLAT; returns positioned in cLAT.
   task automatic watch(input logic r, input logic w, input logic h, input logic [15:0] a,
                        input logic [15:0] wd);
      for (int i = 0; i < LAT; i++) begin
         chk("acc_read", 32'(mem_read), 32'(r));
         chk("acc_write", 32'(mem_write), 32'(w));
         chk("acc_addr", 32'(mem_addr), 32'(a));
         if (w) chk("acc_wdata", 32'(mem_wdata), 32'(wd));
         chk("acc_halt", 32'(mem_halt), 32'(h && (i == LAT - 1)));
         chk("acc_stall", 32'(stall), 32'd1);
         if (i < LAT - 1) begin
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("reset_halted", 32'(halted), 32'd0);
      rst = 1'b1;
   endtask

   initial begin : stim
      int seen;
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      mem[8'h10] = 16'hBEEF;
      mem[8'h11] = 16'h5A5A;
      mem[8'h30] = 16'hC0DE;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_mem_read", 32'(mem_read), 32'd0);
      chk("rst_mem_write", 32'(mem_write), 32'd0);
      chk("rst_mem_halt", 32'(mem_halt), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
      rst = 1'b1;

      // Load 0x0010 -> 0xBEEF after LAT+1 cycles.
      send(16'h0010, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, LAT + 1, 16'hBEEF, 1'b0);
      watch(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0);
      idle(1);
      chk("load_read_cleared", 32'(mem_read), 32'd0);
      chk("load_resp_stall", 32'(stall), 32'd0);
      idle(2);

      // Store then back-to-back load presented in the RESP cycle.
      send(16'h0020, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, LAT + 1, 16'h0000, 1'b0);
      watch(1'b0, 1'b1, 1'b0, 16'h0020, 16'h1234);
      send(16'h0020, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, LAT + 1, 16'h1234, 1'b0);
      watch(1'b1, 1'b0, 1'b0, 16'h0020, 16'h0);
      idle(3);
      chk("rdata_hold", 32'(rsp_rdata), 32'h1234);
      chk("rsp_valid_pulse", 32'(rsp_valid), 32'd0);

      // Read+write error, then read+write+halt (halt ignored).
      send(16'h0030, 16'h5555, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1, 16'h0000, 1'b1);
      chk("rw_no_read", 32'(mem_read), 32'd0);
      chk("rw_no_write", 32'(mem_write), 32'd0);
      send(16'h0030, 16'h5555, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1, 16'h0000, 1'b1);
      chk("rwh_no_halt", 32'(mem_halt), 32'd0);
      idle(1);
      chk("rwh_not_halted", 32'(halted), 32'd0);
      chk("rw_mem_untouched", 32'(mem[8'h30]), 32'hC0DE);
      chk("err_hold", 32'(err), 32'd1);

      // Flush suppresses acceptance.
      send(16'h0010, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, -1, 16'h0, 1'b0);
      chk("flush_no_read", 32'(mem_read), 32'd0);

      // Odd address load.
`ifdef MEM_ALIGN_CHECK_EN
      send(16'h0011, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1, 16'h0000, 1'b1);
      chk("align_no_read", 32'(mem_read), 32'd0);
`else
      send(16'h0011, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, LAT + 1, 16'h5A5A, 1'b0);
      watch(1'b1, 1'b0, 1'b0, 16'h0011, 16'h0);
`endif
      idle(3);

      // Reset asserted mid-access.
      send(16'h0010, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, -1, 16'h0, 1'b0);
      chk("midrst_read_before", 32'(mem_read), 32'd1);
      #1 rst = 1'b0;
      #1;
      chk("midrst_read", 32'(mem_read), 32'd0);
      chk("midrst_stall", 32'(stall), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      seen = rsp_seen;
      idle(LAT + 3);
      chk("midrst_no_rsp", rsp_seen, seen);

      // Halt combined with a load: mem_halt in the last access cycle.
      send(16'h0010, 16'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, LAT + 1, 16'hBEEF, 1'b0);
      watch(1'b1, 1'b0, 1'b1, 16'h0010, 16'h0);
      chk("hl_not_yet_halted", 32'(halted), 32'd0);
      idle(1);
      chk("hl_halted", 32'(halted), 32'd1);
      chk("hl_halt_dropped", 32'(mem_halt), 32'd0);
      do_reset();

      // Bare HALT, then an ignored load.
      send(16'h0000, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1, 16'h0000, 1'b0);
      chk("halt_pulse", 32'(mem_halt), 32'd1);
      chk("halt_sticky", 32'(halted), 32'd1);
      idle(1);
      chk("halt_one_cycle", 32'(mem_halt), 32'd0);
      send(16'h0040, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1, 16'h0, 1'b0);
      chk("halted_ignore_read", 32'(mem_read), 32'd0);
      idle(LAT + 2);
      chk("halted_still_idle", 32'(mem_read), 32'd0);
      chk("halted_hold", 32'(halted), 32'd1);

      for (int i = 0; i < 20 && sbq.size() != 0; i++) @(posedge clk);
      if (sbq.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL rsp_timeout: got %0d pending responses expected 0", sbq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
